ball_engine: RTL
================

// Module: ball_engine
// PURPOSE
//  Ball-motion and scoring engine for Pong; consumer of the paddle positions produced by the paddle controller.
//  Steps the ball one pixel per game tick, bounces it off the side walls and the paddle faces, and detects
//  misses. Updates both scores and drives the ball coordinates to the renderer.
//  Play field is SCREEN_W x SCREEN_H. Upper paddle occupies rows 0..PADDLE_WIDTH-1; lower paddle occupies the
//  bottom PADDLE_WIDTH rows.
// PARAMETERS
//  SCREEN_W      240     field width, px (x = 0..SCREEN_W-1)
//  SCREEN_H      320     field height, px
//  PADDLE_LENGTH 40      paddle length, px; must match the paddle controller
//  PADDLE_WIDTH  4       paddle thickness, px
//  BALL_SIZE     4       ball edge length, px; (ball_x, ball_y) = top-left pixel
//  TICK_DIV      500000  clocks per ball step (>=1)
//  SERVE_DELAY   60      ticks the ball is held at centre before each serve (>=1)
//  WIN_SCORE     9       score that ends the game (1..15)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  start        in   1  level; serve request in IDLE, new-game request in OVER, ignored otherwise
//  paddleU_pos  in   9  upper paddle centre x; paddle spans [pos-(PADDLE_LENGTH/2-1), pos+PADDLE_LENGTH/2]
//  paddleD_pos  in   9  lower paddle centre x, same span rule
//  ball_x       out  9  ball top-left x
//  ball_y       out  9  ball top-left y
//  scoreU       out  4  upper player score
//  scoreD       out  4  lower player score
//  hitU, hitD   out  1  one-clock pulse on a paddle bounce
//  game_over    out  1  high while in OVER
// BEHAVIOUR
//  Reset (any state, takes effect next clock): state=IDLE, ball=((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2)
//   = (118,158), dx=+1, dy=+1, scores=0, hitU=hitD=0, game_over=0, tick counter=0.
//  Tick: free-running counter 0..TICK_DIV-1; tick = (cnt==TICK_DIV-1). All state changes below occur only on
//   tick, except reset and the start-driven transitions out of IDLE and OVER.
//  Paddle inputs are registered every clock. Collision uses the registered values.
//   Span lower bound is clamped at 0 (computed in 10 bits, no underflow).
//  FSM:
//   IDLE : ball at centre; start -> SERVE (serve counter=0).
//   SERVE: ball held; after SERVE_DELAY ticks -> MOVE.
//   MOVE : x and y updated on the same tick, independently.
//    x: dx=-1 & x==0 -> dx=+1, x=1; dx=+1 & x==SCREEN_W-BALL_SIZE -> dx=-1, x-=1; otherwise x+=dx.
//    y up (dy=-1), y==PADDLE_WIDTH, overlap with U span -> dy=+1, y+=1, hitU pulse.
//     Overlap means ball_x+BALL_SIZE-1 >= left and ball_x <= right.
//    y down, y==SCREEN_H-PADDLE_WIDTH-BALL_SIZE, overlap with D span -> dy=-1, y-=1, hitD pulse.
//    No overlap -> ball passes. dy=-1 & y==0 -> POINT (D scores). dy=+1 & y==SCREEN_H-BALL_SIZE -> POINT (U scores).
//   POINT (one clock, no tick needed): scorer += 1.
//    New score == WIN_SCORE -> OVER, ball frozen at its last position.
//    Otherwise ball recentred, dy points toward the conceding player, dx toggles, -> SERVE.
//   OVER : game_over=1, nothing moves; start -> scores=0, ball recentred, dx=+1, dy=+1, -> SERVE.
//  Simultaneous wall and paddle bounce on one tick: both applied. hitU/hitD never assert outside MOVE.
//  Scores saturate by construction: they never exceed WIN_SCORE.
// STRUCTURE
//  pong_pkg: state enum {IDLE,SERVE,MOVE,POINT,OVER}; screen/paddle/ball default constants shared with the
//   paddle controller and renderer.
//  Sub-module tick_gen (TICK_DIV) produces the tick pulse. FSM, datapath and collision logic stay in ball_engine.
// TESTING  (TICK_DIV=1, SERVE_DELAY=2, WIN_SCORE=2 unless noted)
//  1 reset, start=0 for 100 clk -> ball=(118,158), scores 0/0, no hit pulses, game_over=0.
//  2 start, paddles centred on ball path -> after 2 serve ticks ball_x increments by 1 per tick.
//    At x=236 with dx=+1 -> next x=235.
//  3 ball moving up reaches y=4, ball_x=100, paddleU_pos=110 (span 91..130) -> hitU high exactly 1 clk, next y=5.
//  4 same approach, paddleU_pos=20 (span 1..40) -> ball reaches y=0, scoreD=1, ball=(118,158),
//    held 2 ticks, then moves with dy=-1.
//  5 second miss by U -> scoreD=2, game_over=1, ball frozen 50 clk; start -> scores 0/0, game_over=0.
//  6 reset pulsed mid-MOVE -> next clock all reset values; paddleU_pos=5 -> left bound clamps to 0, no underflow hit.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong types, field/paddle/ball constants and paddle span helpers
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        MOVE,
        POINT,
        OVER
    } state_t;

    localparam int SCREEN_W_DEF      = 240;
    localparam int SCREEN_H_DEF      = 320;
    localparam int PADDLE_LENGTH_DEF = 40;
    localparam int PADDLE_WIDTH_DEF  = 4;
    localparam int BALL_SIZE_DEF     = 4;

    // Left edge of a paddle span; computed in 10 bits and clamped at 0 so a
    // paddle hugging the left wall never wraps to a huge bound.
    function automatic logic [9:0] span_left(input logic [8:0] pos, input logic [9:0] reach);
        if ({1'b0, pos} < reach) begin
            return '0;
        end
        return {1'b0, pos} - reach;
    endfunction

    // Right edge of a paddle span; 10 bits so it cannot wrap.
    function automatic logic [9:0] span_right(input logic [8:0] pos, input logic [9:0] reach);
        return {1'b0, pos} + reach;
    endfunction

endpackage

// File: rtl/ball_engine_tick_gen.sv
// rtl/ball_engine_tick_gen.sv - free-running divider producing the one-clock game tick
module tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; tick marks the last count.
    always_ff @(posedge clock) begin
        if (reset || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball motion, wall/paddle bounce, miss detection and scoring
module ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W      = SCREEN_W_DEF,
    parameter int SCREEN_H      = SCREEN_H_DEF,
    parameter int PADDLE_LENGTH = PADDLE_LENGTH_DEF,
    parameter int PADDLE_WIDTH  = PADDLE_WIDTH_DEF,
    parameter int BALL_SIZE     = BALL_SIZE_DEF,
    parameter int TICK_DIV      = 500000,
    parameter int SERVE_DELAY   = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] paddleU_pos,
    input  logic [8:0] paddleD_pos,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] scoreU,
    output logic [3:0] scoreD,
    output logic       hitU,
    output logic       hitD,
    output logic       game_over
);

    localparam logic [8:0] CENTRE_X  = 9'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0] CENTRE_Y  = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [8:0] X_MAX     = 9'(SCREEN_W - BALL_SIZE);
    localparam logic [8:0] Y_PAD_U   = 9'(PADDLE_WIDTH);
    localparam logic [8:0] Y_PAD_D   = 9'(SCREEN_H - PADDLE_WIDTH - BALL_SIZE);
    localparam logic [8:0] Y_MAX     = 9'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] REACH_LO  = 10'(PADDLE_LENGTH / 2 - 1);
    localparam logic [9:0] REACH_HI  = 10'(PADDLE_LENGTH / 2);
    localparam logic [9:0] BALL_EXT  = 10'(BALL_SIZE - 1);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam int         SC_W      = $clog2(SERVE_DELAY + 1);
    localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_DELAY - 1);

    state_t          state;
    logic            tick;
    logic [SC_W-1:0] serve_cnt;
    logic            dx_neg;     // 1: moving left
    logic            dy_up;      // 1: moving toward the upper paddle
    logic            point_u;    // 1: last miss was scored by the upper player
    logic [8:0]      pos_u_q;
    logic [8:0]      pos_d_q;

    logic [9:0] ball_left;
    logic [9:0] ball_right;
    logic       overlap_u;
    logic       overlap_d;
    logic [3:0] next_u;
    logic [3:0] next_d;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign ball_left  = {1'b0, ball_x};
    assign ball_right = ball_left + BALL_EXT;
    assign overlap_u  = (ball_right >= span_left(pos_u_q, REACH_LO)) &&
                        (ball_left  <= span_right(pos_u_q, REACH_HI));
    assign overlap_d  = (ball_right >= span_left(pos_d_q, REACH_LO)) &&
                        (ball_left  <= span_right(pos_d_q, REACH_HI));
    assign next_u     = scoreU + 4'd1;
    assign next_d     = scoreD + 4'd1;

    // Register paddle positions every clock; collision always uses these copies.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_u_q <= '0;
            pos_d_q <= '0;
        end else begin
            pos_u_q <= paddleU_pos;
            pos_d_q <= paddleD_pos;
        end
    end

    // Game FSM with the ball datapath, scoring and registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            dx_neg    <= 1'b0;
            dy_up     <= 1'b0;
            scoreU    <= '0;
            scoreD    <= '0;
            hitU      <= 1'b0;
            hitD      <= 1'b0;
            game_over <= 1'b0;
            serve_cnt <= '0;
            point_u   <= 1'b0;
        end else begin
            hitU <= 1'b0;
            hitD <= 1'b0;
            case (state)
                IDLE: begin
                    ball_x <= CENTRE_X;
                    ball_y <= CENTRE_Y;
                    if (start) begin
                        serve_cnt <= '0;
                        state     <= SERVE;
                    end
                end

                SERVE: begin
                    if (tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            state <= MOVE;
                        end else begin
                            serve_cnt <= serve_cnt + SC_W'(1);
                        end
                    end
                end

                MOVE: begin
                    if (tick) begin
                        // Horizontal: side walls reflect, axis independent of y.
                        if (dx_neg && ball_x == 9'd0) begin
                            dx_neg <= 1'b0;
                            ball_x <= 9'd1;
                        end else if (!dx_neg && ball_x == X_MAX) begin
                            dx_neg <= 1'b1;
                            ball_x <= ball_x - 9'd1;
                        end else if (dx_neg) begin
                            ball_x <= ball_x - 9'd1;
                        end else begin
                            ball_x <= ball_x + 9'd1;
                        end

                        // Vertical: paddle faces reflect, field ends score.
                        if (dy_up) begin
                            if (ball_y == Y_PAD_U && overlap_u) begin
                                dy_up  <= 1'b0;
                                ball_y <= ball_y + 9'd1;
                                hitU   <= 1'b1;
                            end else if (ball_y == 9'd0) begin
                                point_u <= 1'b0;
                                state   <= POINT;
                            end else begin
                                ball_y <= ball_y - 9'd1;
                            end
                        end else begin
                            if (ball_y == Y_PAD_D && overlap_d) begin
                                dy_up  <= 1'b1;
                                ball_y <= ball_y - 9'd1;
                                hitD   <= 1'b1;
                            end else if (ball_y == Y_MAX) begin
                                point_u <= 1'b1;
                                state   <= POINT;
                            end else begin
                                ball_y <= ball_y + 9'd1;
                            end
                        end
                    end
                end

                POINT: begin
                    if (point_u) begin
                        scoreU <= next_u;
                    end else begin
                        scoreD <= next_d;
                    end
                    if ((point_u ? next_u : next_d) == WIN) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        // Next serve heads toward the player who just conceded.
                        ball_x    <= CENTRE_X;
                        ball_y    <= CENTRE_Y;
                        dy_up     <= ~point_u;
                        dx_neg    <= ~dx_neg;
                        serve_cnt <= '0;
                        state     <= SERVE;
                    end
                end

                OVER: begin
                    if (start) begin
                        scoreU    <= '0;
                        scoreD    <= '0;
                        ball_x    <= CENTRE_X;
                        ball_y    <= CENTRE_Y;
                        dx_neg    <= 1'b0;
                        dy_up     <= 1'b0;
                        game_over <= 1'b0;
                        serve_cnt <= '0;
                        state     <= SERVE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
